// File: rtl/twd_mul01_inv.sv
// rtl/twd_mul01_inv.sv - IFFT stage-01 conjugate twiddle multiplier, 2-stage registered pipeline
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   twd01_inv_valid     input beat valid (one beat = 16 lanes)
//   i_01bfly_sum_*      16 lanes x (WIDTH+2) signed, sum branch re/im, lane l at [l*(WIDTH+2) +: WIDTH+2]
//   i_01bfly_diff_*     16 lanes x (WIDTH+2) signed, diff branch re/im
//   twd_01inv_sum_*     16 lanes x (WIDTH+4) signed, rotated sum re/im
//   twd_01inv_diff_*    16 lanes x (WIDTH+4) signed, rotated diff re/im
//   o_twd01_inv_valid   output beat valid, two cycles after the input beat
//   o_twd01_inv_idx     twiddle index applied to the current output beat
module twd_mul01_inv #(
  parameter int WIDTH   = 9,
  parameter int CLK_CNT = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      twd01_inv_valid,
  input  logic [16*(WIDTH+2)-1:0]   i_01bfly_sum_re,
  input  logic [16*(WIDTH+2)-1:0]   i_01bfly_sum_im,
  input  logic [16*(WIDTH+2)-1:0]   i_01bfly_diff_re,
  input  logic [16*(WIDTH+2)-1:0]   i_01bfly_diff_im,
  output logic [16*(WIDTH+4)-1:0]   twd_01inv_sum_re,
  output logic [16*(WIDTH+4)-1:0]   twd_01inv_sum_im,
  output logic [16*(WIDTH+4)-1:0]   twd_01inv_diff_re,
  output logic [16*(WIDTH+4)-1:0]   twd_01inv_diff_im,
  output logic                      o_twd01_inv_valid,
  output logic [1:0]                o_twd01_inv_idx
);

  localparam int NL    = 16;
  localparam int IW    = WIDTH + 2;
  localparam int OW    = WIDTH + 4;
  localparam int PW    = WIDTH + 12;
  localparam int FRAME = 4 * CLK_CNT;
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic [CW-1:0]      r_cnt;
  logic [1:0]         w_idx;

  logic               r_v1;
  logic [1:0]         r_idx1;
  logic [NL*IW-1:0]   r_s_re, r_s_im, r_d_re, r_d_im;

  logic [NL*OW-1:0]   w_s_re, w_s_im, w_d_re, w_d_im;

  // Rotation of one complex sample. Returns {re, im}.
  // Sum branch only rotates at idx 3; diff branch also takes +j at idx 1.
  function automatic logic [2*OW-1:0] f_rot(
    input logic [IW-1:0] a,
    input logic [IW-1:0] b,
    input logic [1:0]    idx,
    input logic          is_diff
  );
    logic signed [OW-1:0] ax, bx;
    logic signed [IW:0]   dif, sm;
    logic signed [PW-1:0] pr, pi;
    logic signed [OW-1:0] re, im;
    ax  = {{(OW-IW){a[IW-1]}}, a};
    bx  = {{(OW-IW){b[IW-1]}}, b};
    dif = {a[IW-1], a} - {b[IW-1], b};
    sm  = {a[IW-1], a} + {b[IW-1], b};
    // Adding 128 before the arithmetic shift rounds half up
    pr  = {{(PW-IW-1){dif[IW]}}, dif} * PW'(181) + PW'(128);
    pi  = {{(PW-IW-1){sm[IW]}},  sm}  * PW'(181) + PW'(128);
    re  = ax;
    im  = bx;
    case (idx)
      2'd1: begin
        if (is_diff) begin
          re = -bx;  // -2^(IW-1) negates exactly at OW bits
          im = ax;
        end
      end
      2'd3: begin
        re = OW'(pr >>> 8);
        im = OW'(pi >>> 8);
      end
      default: begin
        re = ax;
        im = bx;
      end
    endcase
    return {re, im};
  endfunction

  // Twiddle index of the beat presented this cycle
  assign w_idx = 2'(r_cnt / CW'(CLK_CNT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (twd01_inv_valid) begin
      if (r_cnt == CW'(FRAME - 1)) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;
    end
  end

  // Stage 1: capture the beat and its index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1   <= 1'b0;
      r_idx1 <= 2'd0;
      r_s_re <= '0;
      r_s_im <= '0;
      r_d_re <= '0;
      r_d_im <= '0;
    end else begin
      r_v1 <= twd01_inv_valid;
      if (twd01_inv_valid) begin
        r_idx1 <= w_idx;
        r_s_re <= i_01bfly_sum_re;
        r_s_im <= i_01bfly_sum_im;
        r_d_re <= i_01bfly_diff_re;
        r_d_im <= i_01bfly_diff_im;
      end
    end
  end

  always_comb begin
    w_s_re = '0;
    w_s_im = '0;
    w_d_re = '0;
    w_d_im = '0;
    for (int l = 0; l < NL; l++) begin
      {w_s_re[l*OW +: OW], w_s_im[l*OW +: OW]} =
        f_rot(r_s_re[l*IW +: IW], r_s_im[l*IW +: IW], r_idx1, 1'b0);
      {w_d_re[l*OW +: OW], w_d_im[l*OW +: OW]} =
        f_rot(r_d_re[l*IW +: IW], r_d_im[l*IW +: IW], r_idx1, 1'b1);
    end
  end

  // Stage 2: register rotated outputs; data and idx hold between beats
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_twd01_inv_valid <= 1'b0;
      o_twd01_inv_idx   <= 2'd0;
      twd_01inv_sum_re  <= '0;
      twd_01inv_sum_im  <= '0;
      twd_01inv_diff_re <= '0;
      twd_01inv_diff_im <= '0;
    end else begin
      o_twd01_inv_valid <= r_v1;
      if (r_v1) begin
        o_twd01_inv_idx   <= r_idx1;
        twd_01inv_sum_re  <= w_s_re;
        twd_01inv_sum_im  <= w_s_im;
        twd_01inv_diff_re <= w_d_re;
        twd_01inv_diff_im <= w_d_im;
      end
    end
  end

endmodule

// File: tb/tb_twd_mul01_inv.sv
// tb/tb_twd_mul01_inv.sv - directed self-checking bench for twd_mul01_inv
module tb_twd_mul01_inv;

  localparam int IW = 11;
  localparam int OW = 13;

  logic              clk;
  logic              rstn;
  logic              vin;
  logic [16*IW-1:0]  s_re, s_im, d_re, d_im;
  logic [16*OW-1:0]  o_s_re, o_s_im, o_d_re, o_d_im;
  logic              vout;
  logic [1:0]        idx;

  int n_vec = 0;
  int n_err = 0;

  twd_mul01_inv #(.WIDTH(9), .CLK_CNT(4)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .twd01_inv_valid   (vin),
    .i_01bfly_sum_re   (s_re),
    .i_01bfly_sum_im   (s_im),
    .i_01bfly_diff_re  (d_re),
    .i_01bfly_diff_im  (d_im),
    .twd_01inv_sum_re  (o_s_re),
    .twd_01inv_sum_im  (o_s_im),
    .twd_01inv_diff_re (o_d_re),
    .twd_01inv_diff_im (o_d_im),
    .o_twd01_inv_valid (vout),
    .o_twd01_inv_idx   (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16*OW-1:0] rep(input int v);
    logic [OW-1:0] t;
    t = OW'(v);
    return {16{t}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16*OW-1:0] obs, input logic [16*OW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [1:0] ix,
                          input int sr, input int si, input int dr, input int di);
    chk({tag, "_valid"}, {{(16*OW-1){1'b0}}, vout}, {{(16*OW-1){1'b0}}, v});
    chk({tag, "_idx"},   {{(16*OW-2){1'b0}}, idx},  {{(16*OW-2){1'b0}}, ix});
    chk({tag, "_sum_re"},  o_s_re, rep(sr));
    chk({tag, "_sum_im"},  o_s_im, rep(si));
    chk({tag, "_diff_re"}, o_d_re, rep(dr));
    chk({tag, "_diff_im"}, o_d_im, rep(di));
  endtask

  task automatic drive(input int sr, input int si, input int dr, input int di);
    logic [IW-1:0] a, b, c, d;
    a = IW'(sr); b = IW'(si); c = IW'(dr); d = IW'(di);
    s_re = {16{a}}; s_im = {16{b}}; d_re = {16{c}}; d_im = {16{d}};
    vin  = 1'b1;
    tick();
  endtask

  task automatic idle();
    vin = 1'b0;
    tick();
  endtask

  logic [16*OW-1:0] e_sr, e_si, e_dr, e_di;

  initial begin
    rstn = 1'b0;
    vin  = 1'b0;
    s_re = '0; s_im = '0; d_re = '0; d_im = '0;
    tick();
    tick();
    chk_beat("reset", 1'b0, 2'd0, 0, 0, 0, 0);
    rstn = 1'b1;

    // idx 0 beats (cnt 0..3)
    drive(100, -50, 30, 7);          // b0
    drive(1, 2, 3, 4);               // b1
    chk_beat("b0_idx0", 1'b1, 2'd0, 100, -50, 30, 7);
    drive(5, 6, 7, 8);               // b2
    chk_beat("b1_idx0", 1'b1, 2'd0, 1, 2, 3, 4);
    drive(9, 10, 11, 12);            // b3
    chk_beat("b2_idx0", 1'b1, 2'd0, 5, 6, 7, 8);
    // idx 1 beats (cnt 4..7)
    drive(12, -3, 30, 7);            // b4
    chk_beat("b3_idx0", 1'b1, 2'd0, 9, 10, 11, 12);
    drive(3, 3, -5, 9);              // b5
    chk_beat("b4_idx1", 1'b1, 2'd1, 12, -3, -7, 30);
    drive(-20, 40, -20, 40);         // b6
    chk_beat("b5_idx1", 1'b1, 2'd1, 3, 3, -9, -5);
    // three idle cycles: counter parks at 7, outputs hold
    idle();
    chk_beat("b6_idx1", 1'b1, 2'd1, -20, 40, -40, -20);
    idle();
    chk_beat("hold1", 1'b0, 2'd1, -20, 40, -40, -20);
    idle();
    chk_beat("hold2", 1'b0, 2'd1, -20, 40, -40, -20);
    drive(0, -1024, 0, -1024);       // b7, still idx 1
    chk_beat("hold3", 1'b0, 2'd1, -20, 40, -40, -20);
    // idx 2 beats (cnt 8..11)
    drive(7, -7, -100, 50);          // b8
    chk_beat("b7_jneg", 1'b1, 2'd1, 0, -1024, 1024, 0);
    // b9: distinct value per lane
    for (int l = 0; l < 16; l++) begin
      s_re[l*IW +: IW] = IW'(l*7 - 50);
      s_im[l*IW +: IW] = IW'(-l*3);
      d_re[l*IW +: IW] = IW'(l);
      d_im[l*IW +: IW] = IW'(-l - 1);
      e_sr[l*OW +: OW] = OW'(l*7 - 50);
      e_si[l*OW +: OW] = OW'(-l*3);
      e_dr[l*OW +: OW] = OW'(l);
      e_di[l*OW +: OW] = OW'(-l - 1);
    end
    vin = 1'b1;
    tick();
    chk_beat("b8_idx2", 1'b1, 2'd2, 7, -7, -100, 50);
    drive(2, 2, 2, 2);               // b10
    chk("b9_lanes_sum_re", o_s_re, e_sr);
    chk("b9_lanes_sum_im", o_s_im, e_si);
    chk("b9_lanes_diff_re", o_d_re, e_dr);
    chk("b9_lanes_diff_im", o_d_im, e_di);
    drive(3, 3, 3, 3);               // b11
    chk_beat("b10_idx2", 1'b1, 2'd2, 2, 2, 2, 2);
    // idx 3 beats (cnt 12..15)
    drive(256, 0, -100, 50);         // b12
    chk_beat("b11_idx2", 1'b1, 2'd2, 3, 3, 3, 3);
    drive(1023, -1024, 1023, -1024); // b13
    chk_beat("b12_idx3", 1'b1, 2'd3, 181, 181, -106, -35);
    drive(-1024, 1023, 0, 0);        // b14
    // (181*2047+128)>>>8 = 1447 ; (181*(-1)+128)>>>8 = -1
    chk_beat("b13_ext", 1'b1, 2'd3, 1447, -1, 1447, -1);
    drive(0, 0, 0, 0);               // b15
    // (181*(-2047)+128)>>>8 = -1447
    chk_beat("b14_ext", 1'b1, 2'd3, -1447, -1, 0, 0);
    // wrap: next beat back at idx 0
    drive(100, -50, 30, 7);          // b16
    chk_beat("b15_idx3", 1'b1, 2'd3, 0, 0, 0, 0);
    idle();
    chk_beat("b16_wrap", 1'b1, 2'd0, 100, -50, 30, 7);

    // reset mid-frame with beats in flight, counter at idx 1
    drive(1, 1, 1, 1);               // b17
    drive(2, 2, 2, 2);               // b18
    drive(3, 3, 3, 3);               // b19
    drive(4, 4, 4, 4);               // b20 (idx 1)
    vin  = 1'b0;
    rstn = 1'b0;
    #1;
    chk_beat("async_rst", 1'b0, 2'd0, 0, 0, 0, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk_beat("flush1", 1'b0, 2'd0, 0, 0, 0, 0);
    tick();
    chk_beat("flush2", 1'b0, 2'd0, 0, 0, 0, 0);
    drive(12, -3, 30, 7);            // first beat after reset, idx 0
    drive(0, 0, 0, 0);
    chk_beat("post_rst_idx0", 1'b1, 2'd0, 12, -3, 30, 7);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
